// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/jump resolution with mispredict redirect and
// counted flush of the younger stages.
// Optional feature macro: BRANCH_STATS_EN (adds branch/mispredict counters).
module branch_resolve #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [4:0]      alu_op,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            zero,
  input  logic            sign,
  input  logic            overflow,
  input  logic            carry,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            flush_o,
  output logic            resolve_valid_o,
  output logic            resolve_taken_o,
  output logic [XLEN-1:0] resolve_pc_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispredicts_o
`endif
);

  localparam int unsigned CNT_W = 3;

  // Branch ALUOp codes, mirroring ctrl_encode_def
  localparam logic [4:0] ALU_BEQ  = 5'd8;
  localparam logic [4:0] ALU_BNE  = 5'd9;
  localparam logic [4:0] ALU_BLT  = 5'd10;
  localparam logic [4:0] ALU_BGE  = 5'd11;
  localparam logic [4:0] ALU_BLTU = 5'd12;
  localparam logic [4:0] ALU_BGEU = 5'd13;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic               is_branch_c;
  logic               br_taken_c;
  logic               taken_c;
  logic [XLEN-1:0]    jalr_sum_c;
  logic [XLEN-1:0]    target_c;
  logic [XLEN-1:0]    fall_c;
  logic               accept_c;
  logic               mispredict_c;

  logic               redirect_d;
  logic [XLEN-1:0]    redirect_pc_d;
  logic               flush_d;
  logic               resolve_valid_d;
  logic               resolve_taken_d;
  logic [XLEN-1:0]    resolve_pc_d;

  // Actual outcome and target of the EX instruction; jumps override branch ops
  always_comb begin
    is_branch_c = 1'b0;
    br_taken_c  = 1'b0;
    case (alu_op)
      ALU_BEQ:  begin is_branch_c = 1'b1; br_taken_c = zero;                end
      ALU_BNE:  begin is_branch_c = 1'b1; br_taken_c = ~zero;               end
      ALU_BLT:  begin is_branch_c = 1'b1; br_taken_c = sign ^ overflow;     end
      ALU_BGE:  begin is_branch_c = 1'b1; br_taken_c = ~(sign ^ overflow);  end
      ALU_BLTU: begin is_branch_c = 1'b1; br_taken_c = carry;               end
      ALU_BGEU: begin is_branch_c = 1'b1; br_taken_c = ~carry;              end
      default:  ;
    endcase
    jalr_sum_c   = ex_rs1 + ex_imm;
    target_c     = is_jalr ? {jalr_sum_c[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    fall_c       = ex_pc + XLEN'(4);
    taken_c      = (is_jal | is_jalr) ? 1'b1 : br_taken_c;
    accept_c     = ex_valid & ~ex_stall & (state_q == IDLE) &
                   (is_branch_c | is_jal | is_jalr);
    mispredict_c = (taken_c != pred_taken) | (taken_c & (target_c != pred_target));
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a mispredict opens a flush window of FLUSH_CYCLES cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c && mispredict_c) begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    redirect_d      = accept_c & mispredict_c;
    redirect_pc_d   = '0;
    if (redirect_d) begin
      redirect_pc_d = taken_c ? target_c : fall_c;
    end
    flush_d         = (state_d == FLUSH);
    resolve_valid_d = accept_c;
    resolve_taken_d = accept_c & taken_c;
    resolve_pc_d    = accept_c ? ex_pc : '0;
  end

  // Output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_o      <= 1'b0;
      redirect_pc_o   <= '0;
      flush_o         <= 1'b0;
      resolve_valid_o <= 1'b0;
      resolve_taken_o <= 1'b0;
      resolve_pc_o    <= '0;
    end else begin
      redirect_o      <= redirect_d;
      redirect_pc_o   <= redirect_pc_d;
      flush_o         <= flush_d;
      resolve_valid_o <= resolve_valid_d;
      resolve_taken_o <= resolve_taken_d;
      resolve_pc_o    <= resolve_pc_d;
    end
  end

`ifdef BRANCH_STATS_EN
  // Wrap-around resolve and mispredict counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_branches_o    <= '0;
      stat_mispredicts_o <= '0;
    end else if (accept_c) begin
      stat_branches_o <= stat_branches_o + 32'd1;
      if (mispredict_c) begin
        stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases followed by random
// traffic, checked against an operand-level reference model.
module tb_branch_resolve;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned FLUSH_CYCLES = 2;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_BEQ  = 5'd8;
  localparam logic [4:0] ALU_BNE  = 5'd9;
  localparam logic [4:0] ALU_BLT  = 5'd10;
  localparam logic [4:0] ALU_BGE  = 5'd11;
  localparam logic [4:0] ALU_BLTU = 5'd12;
  localparam logic [4:0] ALU_BGEU = 5'd13;

  logic            clk;
  logic            rstn;
  logic            ex_valid;
  logic            ex_stall;
  logic [4:0]      alu_op;
  logic            is_jal;
  logic            is_jalr;
  logic            zero;
  logic            sign;
  logic            overflow;
  logic            carry;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            flush_o;
  logic            resolve_valid_o;
  logic            resolve_taken_o;
  logic [XLEN-1:0] resolve_pc_o;
`ifdef BRANCH_STATS_EN
  logic [31:0]     stat_branches_o;
  logic [31:0]     stat_mispredicts_o;
`endif

  branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .ex_valid        (ex_valid),
    .ex_stall        (ex_stall),
    .alu_op          (alu_op),
    .is_jal          (is_jal),
    .is_jalr         (is_jalr),
    .zero            (zero),
    .sign            (sign),
    .overflow        (overflow),
    .carry           (carry),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_rs1          (ex_rs1),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .flush_o         (flush_o),
    .resolve_valid_o (resolve_valid_o),
    .resolve_taken_o (resolve_taken_o),
    .resolve_pc_o    (resolve_pc_o)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches_o    (stat_branches_o),
    .stat_mispredicts_o (stat_mispredicts_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          errors = 0;
  int unsigned model_rem = 0;
  logic [31:0] m_br = 32'd0;
  logic [31:0] m_mis = 32'd0;
  logic [31:0] opa;
  logic [31:0] opb;

  // Drive the ALU flags as the ALU would for opa - opb
  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    opa      = a;
    opb      = b;
    d        = {1'b0, a} - {1'b0, b};
    zero     = (d[31:0] == 32'd0);
    sign     = d[31];
    overflow = (a[31] != b[31]) && (d[31] != a[31]);
    carry    = d[32];
  endtask

  function automatic logic is_ctl(input logic [4:0] op, input logic j, input logic jr);
    return j || jr || (op >= ALU_BEQ && op <= ALU_BGEU);
  endfunction

  // Outcome from the operands themselves, not from the flags
  function automatic logic exp_taken(input logic [4:0] op, input logic j, input logic jr,
                                     input logic [31:0] a, input logic [31:0] b);
    if (j || jr) return 1'b1;
    case (op)
      ALU_BEQ:  return a == b;
      ALU_BNE:  return a != b;
      ALU_BLT:  return $signed(a) < $signed(b);
      ALU_BGE:  return $signed(a) >= $signed(b);
      ALU_BLTU: return a < b;
      ALU_BGEU: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_target();
    if (is_jalr) return (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    return ex_pc + ex_imm;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict, advance the model at the edge, check at the falling edge
  task automatic tick();
    logic        acc;
    logic        tk;
    logic        mis;
    logic [31:0] tgt;
    acc = ex_valid && !ex_stall && (model_rem == 0) && is_ctl(alu_op, is_jal, is_jalr);
    tk  = exp_taken(alu_op, is_jal, is_jalr, opa, opb);
    tgt = exp_target();
    mis = (tk != pred_taken) || (tk && (tgt != pred_target));
    @(posedge clk);
    if (model_rem > 0) model_rem--;
    if (acc && mis) model_rem = FLUSH_CYCLES;
    if (acc) m_br++;
    if (acc && mis) m_mis++;
    @(negedge clk);
    chk1("resolve_valid", resolve_valid_o, acc);
    chk1("redirect", redirect_o, acc && mis);
    chk1("flush", flush_o, model_rem > 0);
    if (acc) begin
      chk1("resolve_taken", resolve_taken_o, tk);
      chk32("resolve_pc", resolve_pc_o, ex_pc);
    end
    if (acc && mis) chk32("redirect_pc", redirect_pc_o, tk ? tgt : ex_pc + 32'd4);
`ifdef BRANCH_STATS_EN
    chk32("stat_branches", stat_branches_o, m_br);
    chk32("stat_mispredicts", stat_mispredicts_o, m_mis);
`endif
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_stall = 1'b0; alu_op = ALU_ADD; is_jal = 1'b0; is_jalr = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; pred_taken = 1'b0; pred_target = '0;
    set_ops(32'd0, 32'd1);
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b0;
    #1;
    chk1("reset_redirect", redirect_o, 1'b0);
    chk1("reset_flush", flush_o, 1'b0);
    chk1("reset_resolve_valid", resolve_valid_o, 1'b0);
    chk32("reset_redirect_pc", redirect_pc_o, 32'd0);
    chk32("reset_resolve_pc", resolve_pc_o, 32'd0);
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;
    tick();

    // BEQ taken, predicted not taken
    alu_op = ALU_BEQ; set_ops(32'd5, 32'd5); ex_pc = 32'h100; ex_imm = 32'h20;
    pred_taken = 1'b0; pred_target = 32'h0; ex_valid = 1'b1;
    tick();
    chk1("beq_redirect", redirect_o, 1'b1);
    chk32("beq_redirect_pc", redirect_pc_o, 32'h120);
    chk1("beq_taken", resolve_taken_o, 1'b1);
    chk1("beq_flush1", flush_o, 1'b1);
    ex_valid = 1'b0;
    tick();
    chk1("beq_flush2", flush_o, 1'b1);
    tick();
    chk1("beq_flush_end", flush_o, 1'b0);

    // BLT with sign=overflow=1 is not taken, predicted taken
    alu_op = ALU_BLT; set_ops(32'h7FFF_FFFF, 32'hFFFF_FFFF); ex_pc = 32'h200; ex_imm = 32'h40;
    pred_taken = 1'b1; pred_target = 32'h240; ex_valid = 1'b1;
    tick();
    chk32("blt_redirect_pc", redirect_pc_o, 32'h204);
    chk1("blt_taken", resolve_taken_o, 1'b0);
    ex_valid = 1'b0;
    tick(); tick();

    // BLTU correctly predicted, back-to-back accepts
    alu_op = ALU_BLTU; set_ops(32'd1, 32'd2); ex_pc = 32'h300; ex_imm = 32'h10;
    pred_taken = 1'b1; pred_target = 32'h310; ex_valid = 1'b1;
    tick();
    chk1("bltu_resolve1", resolve_valid_o, 1'b1);
    chk1("bltu_no_redirect", redirect_o, 1'b0);
    tick();
    chk1("bltu_resolve2", resolve_valid_o, 1'b1);
    chk1("bltu_no_flush", flush_o, 1'b0);

    // Stall holds off the accept until it drops
    ex_stall = 1'b1;
    tick();
    chk1("stall_no_resolve", resolve_valid_o, 1'b0);
    ex_stall = 1'b0;
    tick();
    chk1("stall_release_resolve", resolve_valid_o, 1'b1);

    // JALR target with bit0 cleared
    alu_op = ALU_ADD; is_jalr = 1'b1; ex_rs1 = 32'h1001; ex_imm = 32'h4;
    pred_taken = 1'b1; pred_target = 32'h1004;
    tick();
    chk1("jalr_hit_redirect", redirect_o, 1'b0);
    pred_target = 32'h1008;
    tick();
    chk1("jalr_miss_redirect", redirect_o, 1'b1);
    chk32("jalr_redirect_pc", redirect_pc_o, 32'h1004);
    ex_valid = 1'b0; is_jalr = 1'b0;
    tick(); tick();

    // JAL with a not-taken branch op: jump wins
    alu_op = ALU_BNE; is_jal = 1'b1; set_ops(32'd7, 32'd7); ex_pc = 32'h500; ex_imm = 32'h80;
    pred_taken = 1'b0; ex_valid = 1'b1;
    tick();
    chk1("jal_taken", resolve_taken_o, 1'b1);
    chk32("jal_redirect_pc", redirect_pc_o, 32'h580);
    is_jal = 1'b0;

    // Wrong-path BEQ during FLUSH, then reset mid-FLUSH
    alu_op = ALU_BEQ; set_ops(32'd3, 32'd3); ex_pc = 32'h600; pred_taken = 1'b0;
    tick();
    chk1("flush_no_resolve", resolve_valid_o, 1'b0);
    chk1("flush_no_redirect", redirect_o, 1'b0);
    chk1("flush_still_high", flush_o, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("async_reset_flush", flush_o, 1'b0);
    model_rem = 0; m_br = 32'd0; m_mis = 32'd0;
    ex_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rstn = 1'b1;

    // Three accepts after reset, one mispredicted
    alu_op = ALU_BNE; set_ops(32'd1, 32'd2); ex_pc = 32'h700; ex_imm = 32'h8;
    pred_taken = 1'b1; pred_target = 32'h708; ex_valid = 1'b1;
    tick();
    chk1("bne_after_reset", resolve_valid_o, 1'b1);
    chk1("bne_after_reset_taken", resolve_taken_o, 1'b1);
    alu_op = ALU_BGEU; set_ops(32'd1, 32'd2); pred_taken = 1'b0;
    tick();
    alu_op = ALU_BGE; set_ops(32'd9, 32'hFFFF_FFF0);
    tick();
    chk1("bge_mispredict", redirect_o, 1'b1);
`ifdef BRANCH_STATS_EN
    chk32("stats_branches3", stat_branches_o, 32'd3);
    chk32("stats_mispredicts1", stat_mispredicts_o, 32'd1);
`endif
    ex_valid = 1'b0;
    tick(); tick();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [31:0] a;
      logic [31:0] b;
      ex_valid = ($urandom_range(0, 9) < 8);
      ex_stall = ($urandom_range(0, 9) < 2);
      r        = $urandom_range(0, 7);
      alu_op   = (r < 6) ? (ALU_BEQ + 5'(r)) : ((r == 6) ? ALU_ADD : 5'd20);
      is_jal   = ($urandom_range(0, 9) == 0);
      is_jalr  = ($urandom_range(0, 9) == 0);
      a        = $urandom;
      b        = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      set_ops(a, b);
      ex_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ex_imm   = $urandom;
      ex_rs1   = $urandom;
      pred_taken  = $urandom_range(0, 1) == 1;
      pred_target = ($urandom_range(0, 1) == 1) ? exp_target() : 32'($urandom);
      tick();
    end

    idle_inputs();
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage consumer of the ALU result flags (Zero, Sign, Overflow, Carry) for the branch ALUOps, and of the jump indications from decode.
- Resolves the real branch/jump outcome and target, then compares them with the prediction carried down from IF.
- On mismatch: registers a one-cycle redirect to IF and drives a counted flush of the younger pipeline stages through a small FSM.

Parameters:
- XLEN, 32, datapath/PC width.
- FLUSH_CYCLES, 2, number of cycles flush_o is held after a redirect (IF/ID depth); legal range 1..7.

Ports:
- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low (fixed: one clock; reset is asynchronous and active-low).
- ex_valid  input  1  EX stage holds a live instruction this cycle.
- ex_stall  input  1  pipeline stall; outcome is not consumed while high.
- alu_op  input  5  ALUOp of the EX instruction; branch codes are ALU_BEQ/BNE/BLT/BGE/BLTU/BGEU from ctrl_encode_def.
- is_jal  input  1  EX instruction is JAL.
- is_jalr  input  1  EX instruction is JALR.
- zero, sign, overflow, carry  input  1 each  ALU flags for the EX instruction.
- ex_pc  input  XLEN  PC of the EX instruction.
- ex_imm  input  XLEN  sign-extended immediate.
- ex_rs1  input  XLEN  forwarded rs1 value (JALR base).
- pred_taken  input  1  IF prediction for this instruction.
- pred_target  input  XLEN  IF predicted target.
- redirect_o  output  1  one-cycle pulse: IF must load redirect_pc_o.
- redirect_pc_o  output  XLEN  corrected fetch address.
- flush_o  output  1  squash IF/ID contents.
- resolve_valid_o  output  1  one-cycle pulse: a branch/jump was resolved (predictor update).
- resolve_taken_o  output  1  actual outcome, valid with resolve_valid_o.
- resolve_pc_o  output  XLEN  PC of the resolved instruction.

Behaviour:
- Outcome rules (combinational):
  - BEQ: zero. BNE: !zero.
  - BLT: sign^overflow. BGE: !(sign^overflow).
  - BLTU: carry, where carry is the borrow of {0,A}-{0,B}. BGEU: !carry.
  - JAL/JALR: always taken. All other ops: not a control-flow instruction.
- Target rules:
  - Branch/JAL: ex_pc+ex_imm. JALR: (ex_rs1+ex_imm) with bit0 cleared.
  - All additions are modulo 2^XLEN.
- Fall-through address: ex_pc+4.
- Mispredict:
  - actual!=pred_taken, OR
  - actual taken and target!=pred_target.
  - A not-taken prediction that resolves not-taken is correct regardless of pred_target.
- Accept condition: ex_valid & !ex_stall & state==IDLE & (branch op | is_jal | is_jalr).
- FSM states: IDLE, FLUSH.
  - IDLE, on accept with mispredict: next cycle redirect_o=1, redirect_pc_o = taken ? target : ex_pc+4, flush_o=1. Enter FLUSH with counter = FLUSH_CYCLES-1.
  - FLUSH: flush_o=1, redirect_o=0, counter decrements each cycle, ex_stall ignored. Return to IDLE the cycle after the counter reaches 0.
  - With FLUSH_CYCLES=1, FLUSH lasts zero extra cycles: the state returns directly to IDLE after the redirect cycle.
  - In FLUSH, all EX inputs are wrong-path. They are never accepted and produce no resolve pulse.
- resolve_valid_o, resolve_taken_o and resolve_pc_o are registered and pulse for one cycle, on the cycle after every accept (mispredict or not).
- Latency: decision is registered one cycle after accept. Redirect and first flush cycle coincide.
- Back-to-back: a correct-prediction accept in IDLE does not block the next cycle's accept.
- Simultaneous events:
  - ex_stall high with ex_valid: no accept; inputs are re-evaluated when the stall drops.
  - is_jal and is_jalr both high: treat as JALR.
  - Jump flag plus a branch alu_op: the jump wins.
- Reset (async, any time, including mid-FLUSH):
  - State returns to IDLE, counter cleared.
  - redirect_o, flush_o, resolve_valid_o, resolve_taken_o = 0; redirect_pc_o and resolve_pc_o = 0.
  - Outputs drop immediately on rstn low.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds output ports stat_branches_o[31:0] and stat_mispredicts_o[31:0].
  - Free-running wrap-around counters: +1 per accept, and +1 per mispredict accept.
  - Both increment in the same cycle as the resolve pulse is set up; both reset to 0 on rstn.
- Not defined: the ports and counters are absent, with no other behavioural change.

Test Plan:
- BEQ, zero=1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle redirect_o=1, redirect_pc_o=0x120, flush_o high for exactly 2 cycles, resolve_taken_o=1.
- BLT, sign=1, overflow=1, pc=0x200, pred_taken=1, pred_target=0x240 -> actual not taken, redirect_pc_o=0x204, resolve_taken_o=0.
- BLTU, carry=1, pc=0x300, imm=0x10, pred_taken=1, pred_target=0x310 -> no redirect, no flush, resolve_valid_o pulses once. Repeat the accept next cycle -> second resolve pulse.
- JALR, rs1=0x1001, imm=0x4, pred_target=0x1004 -> target 0x1004 matches, no redirect. Same case with pred_target=0x1008 -> redirect_pc_o=0x1004.
- Mispredict followed by ex_valid BEQ during FLUSH -> no resolve pulse and no second redirect. Assert rstn low mid-FLUSH -> flush_o=0 immediately; after release, a BNE accept resolves normally.
- With BRANCH_STATS_EN: 3 accepts including 1 mispredict -> stat_branches_o=3, stat_mispredicts_o=1. Preload branch counter to 0xFFFFFFFF, one accept -> wraps to 0.
